counter_timer_dev: RTL
======================

# counter_timer_dev

Three-channel programmable down-counter peripheral, directly downstream of the GPIO/LED port at 0xF0000000. It consumes the 2-bit `counter_set` channel select written through that port, and takes load data and write strobe from the CPU peripheral bus. It provides per-channel terminal outputs and a readback word, so software can poll timer expiry or drive blink rates.

## Interface
Parameters:
- `PRESCALE`, 50000: clk cycles per count tick when prescaling is compiled in; must be ≥1.
- `CNT_W`, 32: counter and reload width.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: reset, synchronous and active-high.
- `counter_we` input 1: write strobe for counter space.
- `counter_ch` input 2: target select, driven from GPIO `counter_set`.
  - 00/01/10: channel 0/1/2 reload register.
  - 11: control register.
- `counter_val` input 32: write data.
- `counter0_out`, `counter1_out`, `counter2_out` output 1 each: channel terminal outputs.
- `counter_out` output 32: registered readback of the `counter_ch` target.

## Operation
- Control register `ctrl[5:0]` holds one 2-bit mode per channel; channel i uses `ctrl[2i+1:2i]`.
  - 00: stop.
  - 01: one-shot.
  - 10: periodic.
  - 11: treated as stop.
- Write to control register (`counter_we`=1, `counter_ch`=11): `ctrl <= counter_val[5:0]`.
  - Counts and outputs are unchanged.
  - Entering stop freezes the count in place.
- Write to channel i (`counter_we`=1, `counter_ch`=i):
  - `reload_i <= counter_val`.
  - `count_i <= counter_val`.
  - `out_i <= 0`.
- Per tick, channel i behaves according to its mode:
  - Stop: hold `count_i` and `out_i`.
  - One-shot:
    - If `count_i` > 1: decrement.
    - If `count_i` == 1: `count_i <= 0` and `out_i <= 1`; `out_i` stays sticky until the next channel write.
    - If `count_i` == 0: hold.
  - Periodic:
    - If `count_i` > 1: decrement.
    - If `count_i` == 1: `count_i <= reload_i` and `out_i` toggles.
    - If `count_i` == 0: hold and do not toggle. This also covers `reload_i` == 0.
- Readback:
  - Channel target: `counter_out <= count_i`.
  - Control target: `counter_out <= {23'b0, out2, out1, out0, ctrl}`.
- Arithmetic is unsigned; there is no wrap below zero.

## Timing
- Reset values: all `count_i`, `reload_i`, and `ctrl` are 0; all `counterN_out` are 0; `counter_out` is 0; the prescaler is 0.
- Write at edge N: new `count_i`, `ctrl`, or `out_i` is visible immediately after edge N.
- `counter_out` has 1-cycle latency: the value after edge N reflects target state before edge N.
- Tick:
  - Prescaler counts 0..`PRESCALE`-1.
  - Tick is asserted on the cycle the prescaler holds `PRESCALE`-1; the prescaler wraps to 0 on that edge.
  - Prescaler free-runs regardless of channel modes.
- A write to channel i and a tick on the same edge: the write wins and the tick is lost for that channel only.
- Reset asserted mid-count: all state returns to reset values on that edge, and the prescaler phase restarts.
- `counter_we` with `counter_ch` changing each cycle: each write is decoded on its own cycle; there is no buffering.

## Configuration
- `COUNTER_PRESCALE_EN`:
  - Defined: ticks come from the `PRESCALE` prescaler.
  - Undefined: tick is constant 1 (every clk); the prescaler logic and `PRESCALE` are unused. Used for simulation speed.

## Structure
- Package `counter_pkg` holds:
  - Mode constants `MODE_STOP`=2'b00, `MODE_ONESHOT`=2'b01, `MODE_PERIODIC`=2'b10.
  - Select constant `CH_CTRL`=2'b11.
- Sub-module `counter_chan` is instantiated three times. It owns `count`, `reload`, and `out`, with inputs `clk`, `rst`, `tick`, `load`, `load_val`, `mode`.
- The top level owns decode, `ctrl`, the prescaler, and the readback mux.

## Test plan
All scenarios run with `COUNTER_PRESCALE_EN` undefined.
1. Reset, then read each target → `counter_out`=0 and all `counterN_out`=0.
2. One-shot:
   - Stimulus: write ch0=5, then ctrl=0x01.
   - Response: `count0` reaches 0 five ticks after ctrl is written; `counter0_out` rises on that edge and stays 1.
   - A further write ch0=3 clears it.
3. Periodic:
   - Stimulus: write ch1=4, then ctrl=0x08.
   - Response: `counter1_out` toggles every 4 cycles; `counter_out` on `counter_ch`=01 reads the sequence 4,3,2,1,4 lagging by 1 cycle.
4. Freeze:
   - Stimulus: ch2=10, ctrl=0x20, 3 ticks, then ctrl=0x00.
   - Response: `count2` holds 7.
   - Re-enable periodic → resumes from 7.
5. Collision and reset:
   - Stimulus: a ch0 write of 9 on the same edge as a tick.
   - Response: `count0`=9, not 8.
   - Asserting `rst` mid-periodic zeroes everything on that edge.
6. Status read with `counter_ch`=11 after scenarios 2–3 → bits [8:6] equal {0, `out1`, 1} and bits [5:0] equal `ctrl`.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the three-channel down-counter peripheral.
package counter_pkg;

  localparam logic [1:0] MODE_STOP     = 2'b00;
  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_PERIODIC = 2'b10;

  localparam logic [1:0] CH_CTRL = 2'b11;

endpackage

// File: rtl/counter_chan.sv
// One down-counter channel: count, reload value and terminal output.
module counter_chan
  import counter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [1:0]       mode,
  output logic [CNT_W-1:0] count,
  output logic             out
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] reload;
  logic             periodic;
  logic             run;

  always_comb begin
    periodic = 1'b0;
    run      = 1'b0;
    case (mode)
      MODE_ONESHOT:  run = 1'b1;
      MODE_PERIODIC: begin
        run      = 1'b1;
        periodic = 1'b1;
      end
      default:       run = 1'b0;
    endcase
  end

  // A load on a tick edge wins; zero always holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      reload <= '0;
      count  <= '0;
      out    <= 1'b0;
    end else if (load) begin
      reload <= load_val;
      count  <= load_val;
      out    <= 1'b0;
    end else if (tick && run) begin
      if (count > ONE) begin
        count <= count - ONE;
      end else if (count == ONE) begin
        if (periodic) begin
          count <= reload;
          out   <= ~out;
        end else begin
          count <= '0;
          out   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/counter_timer_dev.sv
// Three-channel programmable down-counter with control/readback.
// COUNTER_PRESCALE_EN selects PRESCALE-divided ticks; else tick every clk.
module counter_timer_dev
  import counter_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        counter_we,
  input  logic [1:0]  counter_ch,
  input  logic [31:0] counter_val,
  output logic        counter0_out,
  output logic        counter1_out,
  output logic        counter2_out,
  output logic [31:0] counter_out
);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("PRESCALE must be at least 1");
  end

  logic             tick;
  logic [5:0]       ctrl;
  logic [2:0]       load;
  logic             ctrl_we;
  logic [2:0]       outs;
  logic [CNT_W-1:0] cnt [3];
  logic [31:0]      rd;

`ifdef COUNTER_PRESCALE_EN
  logic [31:0] presc;

  assign tick = (presc == 32'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) presc <= '0;
    else             presc <= presc + 32'd1;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    load    = '0;
    ctrl_we = 1'b0;
    if (counter_we) begin
      unique case (counter_ch)
        2'd0:    load[0] = 1'b1;
        2'd1:    load[1] = 1'b1;
        2'd2:    load[2] = 1'b1;
        CH_CTRL: ctrl_we = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          ctrl <= '0;
    else if (ctrl_we) ctrl <= counter_val[5:0];
  end

  for (genvar i = 0; i < 3; i++) begin : g_chan
    counter_chan #(.CNT_W(CNT_W)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .load     (load[i]),
      .load_val (counter_val[CNT_W-1:0]),
      .mode     (ctrl[2*i +: 2]),
      .count    (cnt[i]),
      .out      (outs[i])
    );
  end

  assign counter0_out = outs[0];
  assign counter1_out = outs[1];
  assign counter2_out = outs[2];

  always_comb begin
    rd = '0;
    unique case (counter_ch)
      2'd0:    rd = 32'(cnt[0]);
      2'd1:    rd = 32'(cnt[1]);
      2'd2:    rd = 32'(cnt[2]);
      CH_CTRL: rd = {23'b0, outs, ctrl};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) counter_out <= '0;
    else     counter_out <= rd;
  end

endmodule
